fact_arbiter: RTL and testbench
===============================

# fact_arbiter

Round-robin arbiter that shares one factorial engine among `NREQ` requesters. It takes level requests with a 4-bit operand, issues one job at a time to the engine and waits for the engine's done/error. It returns the 32-bit result, an error flag and the requester ID with a one-cycle ack. It sits between client blocks and the factorial datapath/control pair, and rejects out-of-range operands and hung engine jobs without engine help.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max cycles spent in WAIT before forced error (≥ 16)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  per-requester level request
- `req_n`  in  4*NREQ  packed operands; requester i at bits [4i+3:4i]
- `ack`  out  NREQ  one-hot, one-cycle pulse: result for requester i valid
- `rsp_out`  out  32  factorial result
- `rsp_err`  out  1  result invalid (overflow/engine error/timeout)
- `rsp_id`  out  $clog2(NREQ)  index of served requester
- `busy`  out  1  high in any state other than IDLE
- `eng_go`  out  1  engine start pulse
- `eng_n`  out  4  engine operand
- `eng_out`  in  32  engine result
- `eng_done`  in  1  engine completion
- `eng_error`  in  1  engine error

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req` is high, pick the first high bit scanning from `ptr` upward, modulo NREQ.
  - Latch its index and operand into `cur_id`/`cur_n`. Set `ptr` to (index+1) mod NREQ.
  - If `cur_n` > 12 (`FACT_MAX_N`), go to RESP with err=1 and out=0 (fast reject). Otherwise go to ISSUE.
- **ISSUE:** `eng_go`=1 for exactly one cycle, with `eng_n`=`cur_n`. Clear the timeout counter. Go to WAIT.
- **WAIT:** `eng_go`=0 and `eng_n` held. Counter increments each cycle.
  - `eng_error`: capture err=1, out=0.
  - `eng_done` without `eng_error`: capture err=0, out=`eng_out`.
  - `eng_done` and `eng_error` in the same cycle: error wins.
  - Counter reaches TIMEOUT-1 with neither asserted: err=1, out=0.
  - Any of these moves to RESP.
- **RESP:**
  - `ack[cur_id]`=1 for one cycle; `rsp_out`, `rsp_err`, `rsp_id` are driven from the captured values. Go to IDLE.
  - `rsp_*` hold their values until the next RESP.
- **Requester rule:** hold `req` and `req_n` stable until ack; `req` is low in the cycle after ack. Dropping `req` before ack is illegal; the job still completes and acks.
- **Engine rule:** done/error after ISSUE are honoured only in WAIT. A done/error pulse arriving while in IDLE or RESP is ignored.
- **Fairness:** with all requesters high, grants rotate 0,1,…,NREQ-1,0.

## Timing
- **Reset values:** all outputs 0, state IDLE, `ptr`=0, counter 0. Reset mid-operation aborts the job with no ack; `eng_go` goes low immediately.
- **Latency:** request sampled in IDLE at cycle t.
  - ISSUE at t+1, WAIT from t+2.
  - If the engine reports at cycle t+2+k, RESP/ack is at t+3+k.
  - Fast reject: ack at t+1.
  - Timeout: ack at t+2+TIMEOUT.
- **Throughput:** next grant no earlier than the cycle after RESP. Minimum back-to-back ack spacing is 4 cycles for valid jobs and 2 cycles for rejects.
- **Output registering:** `busy` is registered from state (high ISSUE/WAIT/RESP). `ack`, `eng_go`, `eng_n` and `rsp_*` are all registered outputs.

## Structure
- **Package `fact_pkg`:**
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - `FACT_MAX_N`=12
  - `FACT_NW`=4, `FACT_OW`=32
- **Sub-module `rr_picker`:** combinational. Inputs `req[NREQ]` and `ptr`; outputs `gnt_valid` and `gnt_idx`. Instantiated once. FSM, counter and capture registers stay in `fact_arbiter`.

## Test plan
- **Single request:** `req[2]`=1, n=5, engine done after 6 cycles with 120 -> `ack[2]` pulse, `rsp_out`=120, `rsp_err`=0, `rsp_id`=2; `eng_go` exactly one cycle with `eng_n`=5.
- **Contention:** all four requesters high, n=1,2,3,12 -> acks in order 0,1,2,3 with results 1, 2, 6, 479001600. Next round starts at 0.
- **Fast reject:** n=13 on requester 1 -> ack one cycle after grant, `rsp_err`=1, `rsp_out`=0, `eng_go` never asserted.
- **Engine error/timeout:**
  - done and error together -> err=1, out=0.
  - Engine silent, TIMEOUT=64 -> ack exactly 66 cycles after grant, err=1.
- **Reset in WAIT:** `rst` pulsed mid-job -> all outputs 0 asynchronously, no ack. A fresh request from requester 3 afterwards is served with `ptr` restarted at 0.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial-engine arbiter.
package fact_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } fact_state_e;

  localparam int unsigned FACT_MAX_N = 12;
  localparam int unsigned FACT_NW    = 4;
  localparam int unsigned FACT_OW    = 32;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int unsigned       sum;

  always_comb begin
    // Bit i of req_rot is requester (ptr + i) mod NREQ.
    req_dbl   = {req, req};
    req_rot   = NREQ'(req_dbl >> ptr);
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_valid && req_rot[i]) begin
        gnt_valid = 1'b1;
        sum       = 32'(ptr) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        gnt_idx   = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial engine; fast-rejects large operands and times out
// hung jobs.
module fact_arbiter
  import fact_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [4*NREQ-1:0]       req_n,
  output logic [NREQ-1:0]         ack,
  output logic [FACT_OW-1:0]      rsp_out,
  output logic                    rsp_err,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy,
  output logic                    eng_go,
  output logic [FACT_NW-1:0]      eng_n,
  input  logic [FACT_OW-1:0]      eng_out,
  input  logic                    eng_done,
  input  logic                    eng_error
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  fact_state_e        state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      cur_id_q, cur_id_d;
  logic [FACT_NW-1:0] cur_n_q, cur_n_d;
  logic               eng_go_q, eng_go_d;
  logic [FACT_NW-1:0] eng_n_q, eng_n_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [FACT_OW-1:0] rsp_out_q, rsp_out_d;
  logic               rsp_err_q, rsp_err_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  logic               busy_q, busy_d;

  logic               gnt_valid;
  logic [IW-1:0]      gnt_idx;
  logic [FACT_NW-1:0] pick_n;

  rr_picker #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_rr_picker (
    .req      (req),
    .ptr      (ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    pick_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) pick_n = req_n[FACT_NW*i +: FACT_NW];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    cur_n_d   = cur_n_q;
    eng_go_d  = 1'b0;
    eng_n_d   = eng_n_q;
    ack_d     = '0;
    rsp_out_d = rsp_out_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          cur_id_d = gnt_idx;
          cur_n_d  = pick_n;
          ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (pick_n > FACT_NW'(FACT_MAX_N)) begin
            state_d   = StResp;
            ack_d     = NREQ'(1) << gnt_idx;
            rsp_out_d = '0;
            rsp_err_d = 1'b1;
            rsp_id_d  = gnt_idx;
          end else begin
            state_d  = StIssue;
            eng_go_d = 1'b1;
            eng_n_d  = pick_n;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Error takes priority over done; a timeout only fires when the engine is silent.
        if (eng_error || eng_done || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = StResp;
          ack_d     = NREQ'(1) << cur_id_q;
          rsp_id_d  = cur_id_q;
          rsp_err_d = eng_error || !eng_done;
          rsp_out_d = (!eng_error && eng_done) ? eng_out : '0;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      cur_id_q  <= '0;
      cur_n_q   <= '0;
      eng_go_q  <= 1'b0;
      eng_n_q   <= '0;
      ack_q     <= '0;
      rsp_out_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      cur_id_q  <= cur_id_d;
      cur_n_q   <= cur_n_d;
      eng_go_q  <= eng_go_d;
      eng_n_q   <= eng_n_d;
      ack_q     <= ack_d;
      rsp_out_q <= rsp_out_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign rsp_out = rsp_out_q;
  assign rsp_err = rsp_err_q;
  assign rsp_id  = rsp_id_q;
  assign busy    = busy_q;
  assign eng_go  = eng_go_q;
  assign eng_n   = eng_n_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Self-checking bench for fact_arbiter: directed scenarios followed by randomized jobs against a
// behavioural round-robin/factorial model.
module tb_fact_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_n = '0;
  logic [NREQ-1:0]   ack;
  logic [31:0]       rsp_out;
  logic              rsp_err;
  logic [1:0]        rsp_id;
  logic              busy;
  logic              eng_go;
  logic [3:0]        eng_n;
  logic [31:0]       eng_out = '0;
  logic              eng_done = 1'b0;
  logic              eng_error = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  fact_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_n    (req_n),
    .ack      (ack),
    .rsp_out  (rsp_out),
    .rsp_err  (rsp_err),
    .rsp_id   (rsp_id),
    .busy     (busy),
    .eng_go   (eng_go),
    .eng_n    (eng_n),
    .eng_out  (eng_out),
    .eng_done (eng_done),
    .eng_error(eng_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  // Model winner: first raised request scanning upward from m_ptr, wrapping.
  function automatic int pick();
    for (int s = 0; s < int'(NREQ); s++) begin
      int c;
      c = (m_ptr + s) % int'(NREQ);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int n);
    req[i] = 1'b1;
    req_n[4*i +: 4] = 4'(n);
  endtask

  // Called at #1 after an edge with the DUT idle. mode: 0 done, 1 error, 2 done+error, 3 silent.
  task automatic do_job(input int mode, input int k, input string tag);
    int          id;
    int          n;
    int          ncyc;
    logic        early;
    logic [31:0] exp_out;
    logic        exp_err;
    id = pick();
    if (id < 0) begin
      $display("FAIL %s: no request raised, observed none expected one", tag);
      n_err++;
      return;
    end
    n = int'(req_n[4*id +: 4]);
    m_ptr = (id + 1) % int'(NREQ);
    @(posedge clk); #1;
    if (n > 12) begin
      exp_out = 32'd0;
      exp_err = 1'b1;
      chk({tag, ":reject_go"}, 32'(eng_go), 32'd0);
    end else begin
      chk({tag, ":go"}, 32'(eng_go), 32'd1);
      chk({tag, ":eng_n"}, 32'(eng_n), 32'(n));
      chk({tag, ":busy_issue"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk({tag, ":go_low"}, 32'(eng_go), 32'd0);
      ncyc  = (mode == 3) ? int'(TIMEOUT) : k + 1;
      early = 1'b0;
      for (int j = 0; j < ncyc; j++) begin
        if (mode != 3 && j == k) begin
          eng_done  = (mode != 1);
          eng_error = (mode == 1 || mode == 2);
          eng_out   = fact(n);
        end
        @(posedge clk); #1;
        eng_done  = 1'b0;
        eng_error = 1'b0;
        if (j < ncyc - 1 && ack != '0) early = 1'b1;
      end
      chk({tag, ":early_ack"}, 32'(early), 32'd0);
      exp_err = (mode != 0);
      exp_out = (mode == 0) ? fact(n) : 32'd0;
    end
    chk({tag, ":ack"}, 32'(ack), 32'(1) << id);
    chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(id));
    chk({tag, ":rsp_out"}, rsp_out, exp_out);
    chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ":busy_resp"}, 32'(busy), 32'd1);
    req[id] = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":ack_clear"}, 32'(ack), 32'd0);
    chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
    chk({tag, ":rsp_hold"}, rsp_out, exp_out);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":ack"}, 32'(ack), 32'd0);
    chk({tag, ":rsp_out"}, rsp_out, 32'd0);
    chk({tag, ":rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ":rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    chk({tag, ":eng_go"}, 32'(eng_go), 32'd0);
    chk({tag, ":eng_n"}, 32'(eng_n), 32'd0);
  endtask

  initial begin
    // Reset values
    #1;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single request
    set_req(2, 5);
    do_job(0, 5, "single");

    // Contention: grants rotate 0..3, next round restarts at 0
    set_req(0, 1); set_req(1, 2); set_req(2, 3); set_req(3, 12);
    for (int i = 0; i < 4; i++) do_job(0, i, "contend");
    for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 12));
    for (int i = 0; i < 4; i++) do_job(0, 1, "round2");

    // Fast reject, engine error cases, timeout
    set_req(1, 13);
    do_job(0, 0, "reject");
    set_req(0, 7);
    do_job(2, 3, "both");
    set_req(2, 9);
    do_job(1, 0, "error");
    set_req(3, 4);
    do_job(3, 0, "timeout");

    // Stray engine pulse while idle is ignored
    eng_done = 1'b1;
    eng_out  = 32'hdead_beef;
    @(posedge clk); #1;
    eng_done = 1'b0;
    @(posedge clk); #1;
    chk("stray:ack", 32'(ack), 32'd0);
    chk("stray:busy", 32'(busy), 32'd0);

    // Reset while waiting on the engine
    set_req(1, 3);
    do_job(0, 2, "pre_rst");
    set_req(2, 4);
    @(posedge clk); #1;
    chk("abort:go", 32'(eng_go), 32'd1);
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    req = '0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst   = 1'b0;
    m_ptr = 0;
    chk("post_rst:ack", 32'(ack), 32'd0);
    set_req(1, 2);
    set_req(3, 6);
    do_job(0, 1, "rst_first");
    do_job(0, 2, "rst_second");

    // Randomized jobs
    for (int it = 0; it < 30; it++) begin
      int r;
      int mode;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, 15));
      end
      if (req == '0) set_req($urandom_range(0, NREQ - 1), $urandom_range(0, 15));
      r = $urandom_range(0, 9);
      mode = (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 0;
      do_job(mode, $urandom_range(0, 8), "rand");
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req != '0) do_job(0, 1, "drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
